poly_midi_player: RTL and testbench
===================================

# poly_midi_player

Polyphonic MIDI note player and the next generation of the single-tone MIDI player. It parses a raw MIDI byte stream into note-on and note-off events and allocates up to VOICES simultaneous voices. Each voice has its own phase accumulator and triangle waveform. The voices are mixed into one unsigned offset-binary sample stream for the audio output path.

## Interface
- `VOICES`, 4: number of voices; a power of two, 2..16.
- `ACCUMULATOR_BITS`, 24: width of each voice's phase accumulator.
- `FREQ_BITS`, 16: width of the tone increment, after the ×4 scaling.
- `OUTPUT_BITS`, 16: sample width.
- `SAMPLE_DIV`, 1: number of clocks per sample tick; must be ≥1.
- `clk`  in  1  the single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `midi_data`  in  8  MIDI byte.
- `midi_valid`  in  1  strobe; `midi_data` is consumed on every clock in which this is high.
- `sound_data`  out  OUTPUT_BITS  mixed sample, unsigned offset-binary.
- `sound_valid`  out  1  one-clock pulse on each sample tick.
- `voice_active`  out  VOICES  bit i is set while voice i holds a note.

## Operation
- **Parser FSM.** States are IDLE, ON_KEY, ON_VEL, OFF_KEY, OFF_VEL. State changes only on bytes with `midi_valid`=1.
  - Status byte 0x9n moves the FSM to ON_KEY. Status byte 0x8n moves it to OFF_KEY.
  - Any other status byte (bit7=1) moves it to IDLE. The MIDI channel nibble is ignored (omni mode).
  - A data byte received in IDLE is ignored.
  - ON_KEY or OFF_KEY latches the key from `data[6:0]`, then the FSM moves to the matching _VEL state.
  - ON_VEL with velocity ≠ 0 issues a note-on event. Velocity = 0 issues a note-off event instead.
  - OFF_VEL issues a note-off event.
  - After either _VEL state the FSM returns to the matching _KEY state (running status).
- **Note-on handling.**
  - If any active voice already holds the key, that voice is retriggered: accumulator cleared, no duplicate voice.
  - Otherwise the lowest-index free voice is allocated.
  - On allocation the voice's key is stored and its increment is set to `midi_note_to_tone_freq(key)*4`, truncated to FREQ_BITS. The accumulator is cleared and the `voice_active` bit is set.
  - If all voices are busy, the result depends on the steal feature (see Configuration).
- **Note-off handling.**
  - Clears `voice_active` on every voice holding the key.
  - An unmatched key is ignored.
- **Accumulators.**
  - On each sample tick, every active voice adds its increment, modulo 2^ACCUMULATOR_BITS (natural wrap).
  - Inactive voices hold their accumulator at 0.
- **Waveform.**
  - Phase p is the top OUTPUT_BITS+1 bits of the accumulator.
  - Triangle = p[MSB] ? ~p[OUTPUT_BITS-1:0] : p[OUTPUT_BITS-1:0].
  - An inactive voice contributes midscale, 2^(OUTPUT_BITS-1).
- **Mixer.**
  - Unsigned sum of all VOICES contributions, width OUTPUT_BITS+log2(VOICES).
  - The sum is shifted right by log2(VOICES). No clipping is possible.

## Timing
- **Reset values.** On `rst_n`=0, asynchronously:
  - FSM → IDLE; all voices inactive; accumulators and increments = 0.
  - `voice_active`=0, `sound_valid`=0, `sound_data`=2^(OUTPUT_BITS-1), tick counter = 0.
  - A reset in mid-message discards the partial message.
- **Event latency.** The event fires on the clock that accepts the velocity byte. `voice_active` updates on the following clock edge (1-cycle latency).
- **Sample tick.**
  - The tick counter runs from 0 to SAMPLE_DIV-1; the tick occurs when it wraps to 0.
  - `sound_valid` is high for exactly that clock. With SAMPLE_DIV=1 it is high on every clock.
  - `sound_data` is registered and updates on the tick clock. It reflects the accumulators as they stood before that tick's increment (1 tick of latency).
- **Simultaneous event and tick.** If an event and a tick land on the same clock, the event wins for the affected voice: the accumulator is cleared, not incremented. All other voices advance normally.
- **Flow control.** There is no backpressure; every byte with `midi_valid` is processed in one clock.

## Configuration
- `POLY_MIDI_VOICE_STEAL_EN` defined:
  - A note-on while all voices are busy steals the voice at a round-robin steal pointer, which then advances modulo VOICES.
  - The pointer resets to 0.
- Not defined: a note-on while all voices are busy is dropped. No state changes and there is no steal pointer.

## Structure
- **Package `poly_midi_pkg`** holds:
  - the parser state enum;
  - the status constants NOTE_ON=4'h9 and NOTE_OFF=4'h8;
  - the function `midi_note_to_tone_freq`;
  - the midscale constant function.
- **Sub-module `midi_byte_parser`** contains the parser FSM. Outputs: `note_on`, `note_off` (1-clock pulses) and `key[6:0]`.
- **Top level** contains voice allocation, the accumulators, the waveforms and the mixer.

## Test plan
- **Reset output.** Reset, then idle for 10 clocks → `sound_data`=16'h8000, `voice_active`=0, `sound_valid` high every clock.
- **Single note.** Bytes 0x90,0x45,0x64 → `voice_active`=4'b0001 one clock after the third byte. Voice 0 accumulator grows by `midi_note_to_tone_freq(69)*4` per tick.
- **Running status and vel-0 note-off.** Bytes 0x90,0x3C,0x40,0x40,0x40,0x3C,0x00 → voices 0 and 1 are allocated, then voice 0 is released → `voice_active`=4'b0010.
- **Full voice pool.** Five distinct note-ons with VOICES=4:
  - with `POLY_MIDI_VOICE_STEAL_EN`, voice 0 takes the fifth key;
  - without it, the fifth key is dropped and `voice_active` stays 4'b1111.
- **Retrigger and noise immunity.** A repeated note-on for an active key reuses the same voice (accumulator cleared). Stray bytes are ignored with no state change:
  - data byte 0x22 while in IDLE;
  - status byte 0xB0 followed by data byte 0x07.
- **Reset mid-message and slow ticks.** Assert `rst_n` between key and velocity bytes, then send 0x50 → no note starts. With SAMPLE_DIV=4, `sound_valid` pulses every 4th clock.

Source files
------------

// File: rtl/poly_midi_pkg.sv
`default_nettype none
// ============================================================================
// poly_midi_pkg -- shared types, status codes and helpers for poly_midi_player
// Rev 1.0
// ============================================================================
package poly_midi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ON_KEY  = 3'd1,
    ST_ON_VEL  = 3'd2,
    ST_OFF_KEY = 3'd3,
    ST_OFF_VEL = 3'd4
  } parser_state_t;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;

  // Tone frequency in Hz (A4 = note 69 = 440): top-octave table shifted down per octave.
  function automatic logic [15:0] midi_note_to_tone_freq(input logic [6:0] note);
    logic [3:0]  oct;
    logic [3:0]  semi;
    logic [15:0] base;
    oct  = 4'(note / 7'd12);
    semi = 4'(note % 7'd12);
    case (semi)
      4'd0:    base = 16'd8372;
      4'd1:    base = 16'd8870;
      4'd2:    base = 16'd9397;
      4'd3:    base = 16'd9956;
      4'd4:    base = 16'd10548;
      4'd5:    base = 16'd11175;
      4'd6:    base = 16'd11840;
      4'd7:    base = 16'd12544;
      4'd8:    base = 16'd13290;
      4'd9:    base = 16'd14080;
      4'd10:   base = 16'd14917;
      default: base = 16'd15804;
    endcase
    return base >> (4'd10 - oct);
  endfunction

  function automatic int unsigned midscale(input int unsigned bits);
    return 32'd1 << (bits - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_byte_parser.sv
`default_nettype none
// ============================================================================
// midi_byte_parser -- omni-mode MIDI note-on/note-off parser with running status
// Rev 1.0
// ============================================================================
module midi_byte_parser
  import poly_midi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] midi_data,
  input  logic       midi_valid,
  output logic       note_on,
  output logic       note_off,
  output logic [6:0] key
);

  parser_state_t r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      key      <= 7'd0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      if (midi_valid) begin
        if (midi_data[7]) begin
          if (midi_data[7:4] == NOTE_ON)
            r_state <= ST_ON_KEY;
          else if (midi_data[7:4] == NOTE_OFF)
            r_state <= ST_OFF_KEY;
          else
            r_state <= ST_IDLE;
        end else begin
          case (r_state)
            ST_ON_KEY: begin
              key     <= midi_data[6:0];
              r_state <= ST_ON_VEL;
            end
            ST_OFF_KEY: begin
              key     <= midi_data[6:0];
              r_state <= ST_OFF_VEL;
            end
            // Velocity zero is the common note-off shorthand.
            ST_ON_VEL: begin
              if (midi_data[6:0] != 7'd0)
                note_on <= 1'b1;
              else
                note_off <= 1'b1;
              r_state <= ST_ON_KEY;
            end
            ST_OFF_VEL: begin
              note_off <= 1'b1;
              r_state  <= ST_OFF_KEY;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/poly_midi_player.sv
`default_nettype none
// ============================================================================
// poly_midi_player -- polyphonic MIDI triangle-wave player with voice mixer
// Optional macro: POLY_MIDI_VOICE_STEAL_EN (round-robin steal when pool is full)
// Rev 1.0
// ============================================================================
module poly_midi_player
  import poly_midi_pkg::*;
#(
  parameter int VOICES           = 4,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int FREQ_BITS        = 16,
  parameter int OUTPUT_BITS      = 16,
  parameter int SAMPLE_DIV       = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             midi_data,
  input  logic                   midi_valid,
  output logic [OUTPUT_BITS-1:0] sound_data,
  output logic                   sound_valid,
  output logic [VOICES-1:0]      voice_active
);

  localparam int c_vw    = $clog2(VOICES);
  localparam int c_sum_w = OUTPUT_BITS + c_vw;
  localparam int c_cnt_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [OUTPUT_BITS-1:0] c_midscale = OUTPUT_BITS'(midscale(OUTPUT_BITS));
  localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);

  logic       w_note_on;
  logic       w_note_off;
  logic [6:0] w_key;

  midi_byte_parser u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .midi_data  (midi_data),
    .midi_valid (midi_valid),
    .note_on    (w_note_on),
    .note_off   (w_note_off),
    .key        (w_key)
  );

  logic [ACCUMULATOR_BITS-1:0] r_acc [VOICES];
  logic [FREQ_BITS-1:0]        r_inc [VOICES];
  logic [6:0]                  r_key [VOICES];
  logic [VOICES-1:0]           r_active;
  logic [c_cnt_w-1:0]          r_cnt;

  logic                   w_tick;
  logic [VOICES-1:0]      w_match;
  logic                   w_any_free;
  logic [c_vw-1:0]        w_free_idx;
  logic                   w_alloc_en;
  logic [c_vw-1:0]        w_alloc_idx;
  logic [FREQ_BITS-1:0]   w_new_inc;
  logic [OUTPUT_BITS-1:0] w_voice_out [VOICES];
  logic [c_sum_w-1:0]     w_sum;
  logic [OUTPUT_BITS-1:0] w_mix;

  assign w_tick       = (r_cnt == c_cnt_last);
  assign voice_active = r_active;
  assign w_new_inc    = FREQ_BITS'({16'd0, midi_note_to_tone_freq(w_key), 2'b00});

  generate
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
      logic [OUTPUT_BITS:0]   w_phase;
      logic [OUTPUT_BITS-1:0] w_tri;
      assign w_match[v]     = r_active[v] && (r_key[v] == w_key);
      assign w_phase        = r_acc[v][ACCUMULATOR_BITS-1 -: OUTPUT_BITS+1];
      assign w_tri          = w_phase[OUTPUT_BITS] ? ~w_phase[OUTPUT_BITS-1:0]
                                                   : w_phase[OUTPUT_BITS-1:0];
      assign w_voice_out[v] = r_active[v] ? w_tri : c_midscale;
    end
  endgenerate

  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_any_free = 1'b1;
        w_free_idx = c_vw'(i);
      end
    end
  end

`ifdef POLY_MIDI_VOICE_STEAL_EN
  logic [c_vw-1:0] r_steal_ptr;
  logic            w_steal;

  assign w_steal = w_note_on && !(|w_match) && !w_any_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_steal_ptr <= '0;
    else if (w_steal)
      r_steal_ptr <= r_steal_ptr + 1'b1;
  end

  always_comb begin
    w_alloc_en  = w_note_on && !(|w_match);
    w_alloc_idx = w_any_free ? w_free_idx : r_steal_ptr;
  end
`else
  always_comb begin
    w_alloc_en  = w_note_on && !(|w_match) && w_any_free;
    w_alloc_idx = w_free_idx;
  end
`endif

  // Later assignments win: an event on a tick clock clears rather than advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        r_acc[i] <= '0;
        r_inc[i] <= '0;
        r_key[i] <= '0;
      end
      r_active <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (w_tick && r_active[i])
          r_acc[i] <= r_acc[i] + ACCUMULATOR_BITS'(r_inc[i]);
        if (w_match[i] && (w_note_on || w_note_off))
          r_acc[i] <= '0;
        if (w_match[i] && w_note_off)
          r_active[i] <= 1'b0;
      end
      if (w_alloc_en) begin
        r_key[w_alloc_idx]    <= w_key;
        r_inc[w_alloc_idx]    <= w_new_inc;
        r_acc[w_alloc_idx]    <= '0;
        r_active[w_alloc_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < VOICES; i++)
      w_sum = w_sum + c_sum_w'(w_voice_out[i]);
    w_mix = OUTPUT_BITS'(w_sum >> c_vw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      sound_valid <= 1'b0;
      sound_data  <= c_midscale;
    end else begin
      sound_valid <= w_tick;
      if (w_tick) begin
        r_cnt      <= '0;
        sound_data <= w_mix;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_midi_player.sv
`default_nettype none
// ============================================================================
// tb_poly_midi_player -- vector table, directed corners and random stream vs model
// Rev 1.0
// ============================================================================
module tb_poly_midi_player;
  import poly_midi_pkg::*;

  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  midi_data = 8'd0;
  logic        midi_valid = 1'b0;
  logic [15:0] sound_data, sound_data4;
  logic        sound_valid, sound_valid4;
  logic [3:0]  voice_active, voice_active4;

  always #5 clk = ~clk;

  poly_midi_player #(.VOICES(V), .ACCUMULATOR_BITS(24), .FREQ_BITS(16),
                     .OUTPUT_BITS(16), .SAMPLE_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .sound_data(sound_data), .sound_valid(sound_valid), .voice_active(voice_active));

  poly_midi_player #(.VOICES(V), .ACCUMULATOR_BITS(24), .FREQ_BITS(16),
                     .OUTPUT_BITS(16), .SAMPLE_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .sound_data(sound_data4), .sound_valid(sound_valid4), .voice_active(voice_active4));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-voice state plus a message-level parser.
  bit          m_act [V];
  logic [6:0]  m_key [V];
  int unsigned m_acc [V];
  int unsigned m_inc [V];
  int          m_ptr;
  int          p_mode;      // 0 none, 1 note-on running status, 2 note-off
  bit          p_need_vel;
  logic [6:0]  p_key;
  int          ev_kind;     // event waiting to be applied next clock
  logic [6:0]  ev_key;
  logic [15:0] m_sound;
  bit          m_valid;
  int unsigned m_sum;
  bit          m_found;
  int          m_slot;

  function automatic int unsigned tri_of(input int unsigned acc);
    int unsigned p;
    p = acc >> 7;
    if (((p >> 16) & 1) != 0) return (~p) & 32'hFFFF;
    return p & 32'hFFFF;
  endfunction

  function automatic logic [3:0] m_act_vec();
    logic [3:0] r;
    for (int v = 0; v < V; v++) r[v] = m_act[v];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < V; v++) begin
        m_act[v] = 1'b0; m_key[v] = 7'd0; m_acc[v] = 0; m_inc[v] = 0;
      end
      m_ptr = 0; p_mode = 0; p_need_vel = 1'b0; p_key = 7'd0;
      ev_kind = 0; ev_key = 7'd0; m_sound = 16'h8000; m_valid = 1'b0;
    end else begin
      m_sum = 0;
      for (int v = 0; v < V; v++) m_sum += m_act[v] ? tri_of(m_acc[v]) : 32768;
      m_sound = 16'(m_sum / V);
      m_valid = 1'b1;
      for (int v = 0; v < V; v++)
        if (m_act[v]) m_acc[v] = (m_acc[v] + m_inc[v]) % (1 << 24);
      if (ev_kind == 1) begin
        m_found = 1'b0;
        for (int v = 0; v < V; v++)
          if (m_act[v] && m_key[v] == ev_key) begin m_acc[v] = 0; m_found = 1'b1; end
        if (!m_found) begin
          m_slot = -1;
          for (int v = 0; v < V; v++) if (!m_act[v] && m_slot < 0) m_slot = v;
`ifdef POLY_MIDI_VOICE_STEAL_EN
          if (m_slot < 0) begin m_slot = m_ptr; m_ptr = (m_ptr + 1) % V; end
`endif
          if (m_slot >= 0) begin
            m_act[m_slot] = 1'b1;
            m_key[m_slot] = ev_key;
            m_inc[m_slot] = (32'(midi_note_to_tone_freq(ev_key)) * 4) % 65536;
            m_acc[m_slot] = 0;
          end
        end
      end else if (ev_kind == 2) begin
        for (int v = 0; v < V; v++)
          if (m_act[v] && m_key[v] == ev_key) begin m_act[v] = 1'b0; m_acc[v] = 0; end
      end
      ev_kind = 0;
      if (midi_valid) begin
        if (midi_data[7]) begin
          p_mode = (midi_data[7:4] == 4'h9) ? 1 : (midi_data[7:4] == 4'h8) ? 2 : 0;
          p_need_vel = 1'b0;
        end else if (p_mode != 0) begin
          if (!p_need_vel) begin
            p_key = midi_data[6:0];
            p_need_vel = 1'b1;
          end else begin
            ev_kind = (p_mode == 1 && midi_data[6:0] != 7'd0) ? 1 : 2;
            ev_key = p_key;
            p_need_vel = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("sound_data", {16'd0, sound_data}, {16'd0, m_sound});
      check("voice_active", {28'd0, voice_active}, {28'd0, m_act_vec()});
      check("sound_valid", {31'd0, sound_valid}, {31'd0, m_valid});
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    midi_valid = v;
    midi_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    midi_valid = 1'b0;
    midi_data = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [4:0]   n;
    logic [127:0] bytes;   // first byte in bits [127:120]
    logic [3:0]   exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int n, input logic [127:0] lit, input logic [3:0] exp);
    vec_t t;
    t.n = 5'(n);
    t.bytes = lit << ((16 - n) * 8);
    t.exp = exp;
    tbl.push_back(t);
  endtask

  logic [23:0] acc_prev;
  int          pulses4;
  logic [7:0]  rb;
  int          r;

  initial begin
    add_vec(3,  128'h904564, 4'b0001);
    add_vec(7,  128'h903C4040403C00, 4'b0010);
    add_vec(11, 128'h90307F317F327F337F347F, 4'b1111);
`ifdef POLY_MIDI_VOICE_STEAL_EN
    add_vec(14, 128'h90307F317F327F337F347F803400, 4'b1110);
    add_vec(14, 128'h90307F317F327F337F347F803040, 4'b1111);
`else
    add_vec(14, 128'h90307F317F327F337F347F803400, 4'b1111);
    add_vec(14, 128'h90307F317F327F337F347F803040, 4'b1110);
`endif
    add_vec(1,  128'h22, 4'b0000);
    add_vec(2,  128'hB007, 4'b0000);
    add_vec(6,  128'h22B007904564, 4'b0001);
    add_vec(5,  128'h904564B007, 4'b0001);
    add_vec(5,  128'h9045644564, 4'b0001);
    add_vec(6,  128'h904564804640, 4'b0001);
    add_vec(6,  128'h904564804540, 4'b0000);
    add_vec(6,  128'h9F45648A4500, 4'b0000);
    add_vec(6,  128'h904564904764, 4'b0011);

    check("tone69", {16'd0, midi_note_to_tone_freq(7'd69)}, 32'd440);
    check("tone60", {16'd0, midi_note_to_tone_freq(7'd60)}, 32'd261);
    check("tone127", {16'd0, midi_note_to_tone_freq(7'd127)}, 32'd12544);
    check("tone0", {16'd0, midi_note_to_tone_freq(7'd0)}, 32'd8);

    // Reset state and tick cadence of both sample dividers.
    do_reset();
    chk_en = 1'b1;
    pulses4 = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i <= 10) begin
        check("rst_sound_data", {16'd0, sound_data}, 32'h8000);
        check("rst_voice_active", {28'd0, voice_active}, 32'd0);
        check("rst_sound_valid", {31'd0, sound_valid}, 32'd1);
      end
      check("div4_valid", {31'd0, sound_valid4}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (sound_valid4) pulses4++;
    end
    check("div4_pulses", pulses4, 32'd4);
    check("div4_sound_data", {16'd0, sound_data4}, 32'h8000);

    // Single note: activation latency and per-tick accumulator growth.
    do_reset();
    drive(1'b1, 8'h90);
    drive(1'b1, 8'h45);
    drive(1'b1, 8'h64);
    check("note_not_yet", {28'd0, voice_active}, 32'd0);
    drive(1'b0, 8'h00);
    check("note_active", {28'd0, voice_active}, 32'd1);
    check("acc0_start", {8'd0, dut.r_acc[0]}, 32'd0);
    drive(1'b0, 8'h00);
    check("acc0_tick1", {8'd0, dut.r_acc[0]}, 32'd1760);
    acc_prev = dut.r_acc[0];
    drive(1'b0, 8'h00);
    check("acc0_step", {8'd0, dut.r_acc[0] - acc_prev}, 32'd1760);
    drive(1'b1, 8'h45);
    drive(1'b1, 8'h7F);
    drive(1'b0, 8'h00);
    check("retrig_acc0", {8'd0, dut.r_acc[0]}, 32'd0);
    check("retrig_active", {28'd0, voice_active}, 32'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      do_reset();
      for (int i = 0; i < int'(tbl[k].n); i++)
        drive(1'b1, tbl[k].bytes[127 - 8 * i -: 8]);
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      check($sformatf("table[%0d]", k), {28'd0, voice_active}, {28'd0, tbl[k].exp});
    end

    // Reset between key and velocity discards the partial message.
    do_reset();
    drive(1'b1, 8'h90);
    drive(1'b1, 8'h45);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 8'h50);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("midmsg_reset", {28'd0, voice_active}, 32'd0);
    check("midmsg_reset4", {28'd0, voice_active4}, 32'd0);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       rb = 8'h90 | 8'($urandom_range(0, 15));
      else if (r < 14) rb = 8'h80 | 8'($urandom_range(0, 15));
      else if (r < 16) rb = 8'hB0;
      else if (r < 60) rb = 8'h3C + 8'($urandom_range(0, 5));
      else if (r < 70) rb = 8'h00;
      else             rb = 8'($urandom_range(0, 127));
      drive($urandom_range(0, 3) != 0, rb);
    end
    drive(1'b0, 8'h00);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
